// File: rtl/lcd_mem_arbiter_pkg.sv
// Shared defaults and grant encoding for the CPU/LCD single-port RAM arbiter.
package lcd_mem_arbiter_pkg;

    localparam int AW_DEF       = 12;
    localparam int DW_DEF       = 32;
    localparam int MAX_HOLD_DEF = 16;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_A    = 2'd1,
        GNT_B    = 2'd2
    } gnt_e;

    // Counter width able to hold 0..max_hold inclusive.
    function automatic int hold_w(input int max_hold);
        return $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/lcd_rr_grant.sv
// Round-robin grant between CPU (A) and LCD (B) with a bounded B lock.
// Purely combinational: one grant per cycle from requests plus registered history.
module lcd_rr_grant
    import lcd_mem_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int HW       = hold_w(MAX_HOLD)
) (
    input  logic          a_req,
    input  logic          b_req,
    input  logic          b_lock,
    input  logic          b_won_prev,
    input  gnt_e          last_grant,
    input  logic [HW-1:0] hold_cnt,
    output gnt_e          grant
);

    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    logic lock_hit;

    always_comb begin
        lock_hit = b_won_prev && b_lock && (hold_cnt < HOLD_MAX);
        grant    = GNT_NONE;
        if (a_req && b_req) begin
            // Lock keeps B on the RAM until A has been starved MAX_HOLD times.
            grant = (lock_hit || (last_grant == GNT_A)) ? GNT_B : GNT_A;
        end else if (a_req) begin
            grant = GNT_A;
        end else if (b_req) begin
            grant = GNT_B;
        end
    end

endmodule

// File: rtl/lcd_mem_arbiter.sv
// Two-port (CPU A / LCD B) arbiter onto a single-port RAM with 1-cycle read latency.
// One transfer per cycle; the losing or idle port sees waitrequest high.
module lcd_mem_arbiter
    import lcd_mem_arbiter_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic            clk,
    input  logic            reset,

    input  logic [AW-1:0]   a_address,
    input  logic [DW/8-1:0] a_byteenable,
    input  logic            a_read,
    input  logic            a_write,
    input  logic [DW-1:0]   a_writedata,
    output logic            a_waitrequest,
    output logic [DW-1:0]   a_readdata,
    output logic            a_readdatavalid,

    input  logic [AW-1:0]   b_address,
    input  logic [DW/8-1:0] b_byteenable,
    input  logic            b_read,
    input  logic            b_write,
    input  logic [DW-1:0]   b_writedata,
    input  logic            b_lock,
    output logic            b_waitrequest,
    output logic [DW-1:0]   b_readdata,
    output logic            b_readdatavalid,

    output logic [AW-1:0]   mem_address,
    output logic [DW/8-1:0] mem_byteenable,
    output logic [DW-1:0]   mem_writedata,
    output logic            mem_chipselect,
    output logic            mem_write,
    output logic            mem_clken,
    input  logic [DW-1:0]   mem_readdata
);

    localparam int HW = hold_w(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    gnt_e          last_grant_q, last_grant_d;
    logic          b_won_q, b_won_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          rd_pending_q, rd_pending_d;
    logic          rd_owner_q, rd_owner_d;

    logic a_act, b_act;
    logic gnt_a, gnt_b;
    logic win_read, win_write;
    gnt_e grant;

    assign a_act = a_read | a_write;
    assign b_act = b_read | b_write;

    lcd_rr_grant #(
        .MAX_HOLD (MAX_HOLD),
        .HW       (HW)
    ) u_grant (
        .a_req      (a_act),
        .b_req      (b_act),
        .b_lock     (b_lock),
        .b_won_prev (b_won_q),
        .last_grant (last_grant_q),
        .hold_cnt   (hold_cnt_q),
        .grant      (grant)
    );

    assign gnt_a = !reset && (grant == GNT_A);
    assign gnt_b = !reset && (grant == GNT_B);

    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        win_read       = 1'b0;
        win_write      = 1'b0;
        if (gnt_a) begin
            mem_address    = a_address;
            mem_byteenable = a_byteenable;
            mem_writedata  = a_writedata;
            win_read       = a_read;
            win_write      = a_write;
        end else if (gnt_b) begin
            mem_address    = b_address;
            mem_byteenable = b_byteenable;
            mem_writedata  = b_writedata;
            win_read       = b_read;
            win_write      = b_write;
        end
    end

    assign mem_chipselect = gnt_a | gnt_b;
    assign mem_write      = win_write;
    assign mem_clken      = !reset;
    assign a_waitrequest  = !gnt_a;
    assign b_waitrequest  = !gnt_b;

    // Read data comes straight from the RAM; only the valid strobe is steered.
    assign a_readdata      = mem_readdata;
    assign b_readdata      = mem_readdata;
    assign a_readdatavalid = !reset && rd_pending_q && !rd_owner_q;
    assign b_readdatavalid = !reset && rd_pending_q &&  rd_owner_q;

    always_comb begin
        rd_pending_d = mem_chipselect && win_read && !win_write;
        rd_owner_d   = gnt_b;
        b_won_d      = gnt_b;

        last_grant_d = last_grant_q;
        if (gnt_a)      last_grant_d = GNT_A;
        else if (gnt_b) last_grant_d = GNT_B;

        // Counts B grants that starve A; cleared as soon as B loses the RAM.
        hold_cnt_d = '0;
        if (gnt_b && a_act) begin
            hold_cnt_d = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + 1'b1;
        end else if (gnt_b) begin
            hold_cnt_d = hold_cnt_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= GNT_B;
            b_won_q      <= 1'b0;
            hold_cnt_q   <= '0;
            rd_pending_q <= 1'b0;
            rd_owner_q   <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            b_won_q      <= b_won_d;
            hold_cnt_q   <= hold_cnt_d;
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

endmodule

// File: tb/tb_lcd_mem_arbiter.sv
// Directed bench for lcd_mem_arbiter with a behavioural RAM and a read-return scoreboard.
module tb_lcd_mem_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] a_address, b_address;
    logic [3:0]    a_byteenable, b_byteenable;
    logic          a_read, a_write, b_read, b_write, b_lock;
    logic [DW-1:0] a_writedata, b_writedata;
    logic          a_waitrequest, b_waitrequest;
    logic [DW-1:0] a_readdata, b_readdata;
    logic          a_readdatavalid, b_readdatavalid;
    logic [AW-1:0] mem_address;
    logic [3:0]    mem_byteenable;
    logic [DW-1:0] mem_writedata;
    logic          mem_chipselect, mem_write, mem_clken;
    logic [DW-1:0] mem_readdata;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic          port_b;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb[$];

    logic [DW-1:0] ram [0:(1<<AW)-1];

    always #5 clk = ~clk;

    lcd_mem_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .a_address       (a_address),
        .a_byteenable    (a_byteenable),
        .a_read          (a_read),
        .a_write         (a_write),
        .a_writedata     (a_writedata),
        .a_waitrequest   (a_waitrequest),
        .a_readdata      (a_readdata),
        .a_readdatavalid (a_readdatavalid),
        .b_address       (b_address),
        .b_byteenable    (b_byteenable),
        .b_read          (b_read),
        .b_write         (b_write),
        .b_writedata     (b_writedata),
        .b_lock          (b_lock),
        .b_waitrequest   (b_waitrequest),
        .b_readdata      (b_readdata),
        .b_readdatavalid (b_readdatavalid),
        .mem_address     (mem_address),
        .mem_byteenable  (mem_byteenable),
        .mem_writedata   (mem_writedata),
        .mem_chipselect  (mem_chipselect),
        .mem_write       (mem_write),
        .mem_clken       (mem_clken),
        .mem_readdata    (mem_readdata)
    );

    function automatic logic [DW-1:0] pat(input int i);
        return 32'hC0DE_0000 | i;
    endfunction

    // Single-port RAM, 1-cycle read latency, byte-lane writes.
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int k = 0; k < 4; k++)
                    if (mem_byteenable[k]) ram[mem_address][k*8 +: 8] <= mem_writedata[k*8 +: 8];
            end
            mem_readdata <= ram[mem_address];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // g: 0 = no grant, 1 = A, 2 = B
    task automatic chk_gnt(input string tag, input int g);
        check(tag, {61'd0, a_waitrequest, b_waitrequest, mem_chipselect},
                   {61'd0, g != 1, g != 2, g != 0});
    endtask

    task automatic push(input logic port_b, input logic [DW-1:0] data);
        exp_t e;
        e.port_b = port_b;
        e.data   = data;
        sb.push_back(e);
    endtask

    task automatic idle();
        a_read = 0; a_write = 0; b_read = 0; b_write = 0;
    endtask

    always @(negedge clk) begin
        if (a_readdatavalid || b_readdatavalid) begin
            if (sb.size() == 0) begin
                check("rdv_unexpected", {62'd0, a_readdatavalid, b_readdatavalid}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rdv_port", {62'd0, b_readdatavalid, a_readdatavalid},
                                  {62'd0, e.port_b, !e.port_b});
                check("rdv_data", {32'd0, e.port_b ? b_readdata : a_readdata}, {32'd0, e.data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = pat(i);
        mem_readdata = '0;
        reset = 1;
        a_address = 12'h100; b_address = 12'h200;
        a_byteenable = 4'hF; b_byteenable = 4'hF;
        a_writedata = '0; b_writedata = '0;
        a_read = 1; a_write = 0; b_read = 1; b_write = 0; b_lock = 0;

        // Reset holds outputs quiet even with both ports requesting.
        @(negedge clk); @(negedge clk); #1;
        check("reset_outputs", {57'd0, a_waitrequest, b_waitrequest, a_readdatavalid,
                                b_readdatavalid, mem_chipselect, mem_write, mem_clken},
                               {57'd0, 7'b1100000});

        // Both reading on the first cycle after reset: A, B, A, B.
        @(negedge clk); reset = 0; #1;
        chk_gnt("tie_first_a", 1);
        check("tie_first_addr", {52'd0, mem_address}, {52'd0, 12'h100});
        check("clken_run", {63'd0, mem_clken}, 64'd1);
        push(0, pat(12'h100));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk_gnt("alternate", (i % 2 == 0) ? 2 : 1);
            check("alternate_addr", {52'd0, mem_address}, {52'd0, (i % 2 == 0) ? 12'h200 : 12'h100});
            push(i % 2 == 0, (i % 2 == 0) ? pat(12'h200) : pat(12'h100));
        end

        // Lone A read of 0x010.
        @(negedge clk); idle(); a_read = 1; a_address = 12'h010; #1;
        chk_gnt("a_read_gnt", 1);
        check("a_read_addr", {52'd0, mem_address}, {52'd0, 12'h010});
        check("a_read_nowrite", {63'd0, mem_write}, 64'd0);
        push(0, pat(12'h010));
        @(negedge clk); idle(); #1;
        chk_gnt("idle_nogrant", 0);
        check("idle_a_rdv", {63'd0, a_readdatavalid}, 64'd1);

        // Partial write then readback.
        @(negedge clk); a_write = 1; a_address = 12'h020; a_writedata = 32'hDEADBEEF; a_byteenable = 4'h3; #1;
        chk_gnt("wr_gnt", 1);
        check("wr_bus", {mem_write, 3'd0, mem_byteenable, mem_address, mem_writedata[31:0], 12'd0},
                        {1'b1, 3'd0, 4'h3, 12'h020, 32'hDEADBEEF, 12'd0});
        @(negedge clk); a_write = 0; a_read = 1; a_byteenable = 4'hF; #1;
        check("wr_one_cycle", {63'd0, mem_write}, 64'd0);
        push(0, 32'hC0DE_BEEF);

        // Read and write together behave as a write.
        @(negedge clk); a_read = 1; a_write = 1; a_address = 12'h030; a_writedata = 32'h12345678; #1;
        chk_gnt("rw_gnt", 1);
        check("rw_is_write", {63'd0, mem_write}, 64'd1);
        @(negedge clk); idle(); #1;
        check("rw_no_rdv", {63'd0, a_readdatavalid}, 64'd0);
        @(negedge clk); a_read = 1; #1;
        push(0, 32'h12345678);

        // B lock against an active A: lone B, 16 locked B, one A, then B.
        @(negedge clk); idle(); b_read = 1; b_lock = 1; b_address = 12'h300; a_address = 12'h301; #1;
        chk_gnt("lock_b_alone", 2);
        push(1, pat(12'h300));
        @(negedge clk); a_read = 1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk_gnt("lock_seq", (i == 16) ? 1 : 2);
            check("lock_addr", {52'd0, mem_address}, {52'd0, (i == 16) ? 12'h301 : 12'h300});
            push(i != 16, (i == 16) ? pat(12'h301) : pat(12'h300));
        end
        @(negedge clk); idle(); b_lock = 0;
        @(negedge clk);

        // Reset right after an accepted B read drops its return strobe.
        @(negedge clk); b_read = 1; b_address = 12'h040; #1;
        chk_gnt("rst_b_gnt", 2);
        @(posedge clk); #1; reset = 1; b_read = 0;
        @(negedge clk); #1;
        check("rst_mid_outputs", {57'd0, a_waitrequest, b_waitrequest, a_readdatavalid,
                                  b_readdatavalid, mem_chipselect, mem_write, mem_clken},
                                 {57'd0, 7'b1100000});
        @(negedge clk); reset = 0; #1;
        check("rst_release_rdv", {62'd0, a_readdatavalid, b_readdatavalid}, 64'd0);
        chk_gnt("rst_release_idle", 0);
        @(negedge clk); #1;
        check("rst_after_rdv", {62'd0, a_readdatavalid, b_readdatavalid}, 64'd0);

        @(negedge clk); @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_mem_arbiter.md
LCD_MEM_ARBITER -- requirements
Module: lcd_mem_arbiter

Interface
REQ-001 Parameters SHALL be: AW, 12, word address width; DW, 32, data width; MAX_HOLD, 16, max consecutive locked B grants while A waits.
REQ-002 Ports SHALL include `clk`  in  1  single clock, all logic on the rising edge.
REQ-003 Ports SHALL include `reset`  in  1  asynchronous, active-high reset.
REQ-004 Ports SHALL include `a_address` / `b_address`  in  AW  requester word address (A = CPU port, B = LCD fetch port).
REQ-005 Ports SHALL include `a_byteenable` / `b_byteenable`  in  DW/8  byte lanes for writes.
REQ-006 Ports SHALL include `a_read`, `a_write` / `b_read`, `b_write`  in  1  command strobes.
REQ-007 Ports SHALL include `a_writedata` / `b_writedata`  in  DW  write data.
REQ-008 Ports SHALL include `a_waitrequest` / `b_waitrequest`  out  1  a high value means the command is not accepted this cycle.
REQ-009 Ports SHALL include `a_readdata` / `b_readdata`  out  DW  read data.
REQ-010 Ports SHALL include `a_readdatavalid` / `b_readdatavalid`  out  1  read data valid strobe.
REQ-011 Ports SHALL include `b_lock`  in  1  B requests to keep its grant across consecutive transfers.
REQ-012 Ports SHALL include `mem_address`  out  AW, `mem_byteenable`  out  DW/8, `mem_writedata`  out  DW  to the single-port RAM.
REQ-013 Ports SHALL include `mem_chipselect`, `mem_write`, `mem_clken`  out  1, and `mem_readdata`  in  DW  from the RAM (1-cycle read latency).

Function
REQ-014 A requester is active in a cycle when its read or write strobe is high; a command is accepted when it is active and its waitrequest is low.
REQ-015 At most one requester SHALL be granted per cycle; the grant decision is combinational from the current requests plus registered state (`last_grant`, `hold_cnt`).
REQ-016 Arbitration SHALL be round-robin: when only one requester is active, it wins; when both are active, the one not in `last_grant` wins, except as stated in REQ-017.
REQ-017 When B won the previous cycle, `b_lock`=1, B is active and `hold_cnt`<MAX_HOLD, B SHALL win even if A is active.
REQ-018 When `hold_cnt` reaches MAX_HOLD with A active, A SHALL win the next cycle; `hold_cnt` clears on any A grant or any cycle where B is not granted.
REQ-019 `hold_cnt` SHALL increment only on a B grant while A is active; it saturates at MAX_HOLD and is 5 bits wide for MAX_HOLD=16.
REQ-020 In a grant cycle, the mem_* outputs SHALL mirror the winner's address, byteenable and writedata; `mem_chipselect`=1; `mem_write`=the winner's write.
REQ-021 With no grant, `mem_chipselect`=0 and `mem_write`=0.
REQ-022 If read and write are both high, the command SHALL be treated as a write and no readdatavalid is produced.
REQ-023 An accepted read in cycle N SHALL give readdatavalid=1 for exactly cycle N+1 on the winner's port, with `readdata`=`mem_readdata`. Throughput is one transfer per cycle, with back-to-back reads pipelined.
REQ-024 The non-winner's readdatavalid SHALL be 0; both ports' readdata SHALL be driven from `mem_readdata`.
REQ-025 A registered `rd_pending`/`rd_owner` pair SHALL track the outstanding read.
REQ-026 `mem_clken` SHALL be 1 whenever not in reset.
REQ-027 The loser's waitrequest SHALL be 1 while it is active; an idle port's waitrequest SHALL be 1 (the winner's is 0).

Reset
REQ-028 While `reset`=1, the block SHALL hold: waitrequests 1, readdatavalids 0, `mem_chipselect` 0, `mem_write` 0, `mem_clken` 0, `hold_cnt` 0, `rd_pending` 0, `last_grant`=B (so A wins the first tie).
REQ-029 Reset asserted mid-operation SHALL discard any pending readdatavalid; no strobe is emitted after reset release for a pre-reset read.

Structure
REQ-030 A shared package SHALL hold AW/DW defaults, the grant encoding (GNT_NONE, GNT_A, GNT_B) and the MAX_HOLD default.
REQ-031 The round-robin/lock decision SHALL be one sub-module, `lcd_rr_grant` (requests, lock, `last_grant`, `hold_cnt` in; grant out); the datapath mux and read-return tracking remain in the top level.

Verification
REQ-032 The bench SHALL cover: A read of 0x010 alone -> `mem_address`=0x010, `a_waitrequest`=0, `a_readdatavalid` the next cycle with the RAM word.
REQ-033 The bench SHALL cover: A and B both reading on the first cycle after reset -> A granted, B waits one cycle, then B is granted; alternation A,B,A,B while both stay active.
REQ-034 The bench SHALL cover: B with `b_lock`=1 plus A active for 20 cycles -> 16 consecutive B grants, then 1 A grant, then B again.
REQ-035 The bench SHALL cover: A write 0xDEADBEEF, byteenable 0x3, to 0x020; then A read of 0x020 -> `mem_write`=1 for one cycle; the readback has the low 16 bits 0xBEEF.
REQ-036 The bench SHALL cover: reset asserted in the cycle after an accepted B read -> `b_readdatavalid` stays 0, all outputs at reset values.
REQ-037 The bench SHALL cover: A with read and write both high -> write performed, `a_readdatavalid` stays 0.
